// File: rtl/dma_bank_arbiter_if.sv
// CPU/DMA bus-cycle signals shared by the bank arbiter and its environment;
// master is the arbiter side, slave the CPU/DMA/bus side.
interface dma_bank_arbiter_if;
  logic        phi2;
  logic        cpu_r_w;
  logic [15:0] cpu_address;
  logic [3:0]  cpu_bank;
  logic        cpu_rdy;
  logic        dma_req;
  logic        dma_gnt;
  logic        dma_r_w;
  logic [19:0] dma_address;
  logic [19:0] bus_address;
  logic        bus_r_w;
  logic        bus_owner;

  modport master (
    input  phi2, cpu_r_w, cpu_address, cpu_bank, dma_req, dma_r_w, dma_address,
    output cpu_rdy, dma_gnt, bus_address, bus_r_w, bus_owner
  );

  modport slave (
    output phi2, cpu_r_w, cpu_address, cpu_bank, dma_req, dma_r_w, dma_address,
    input  cpu_rdy, dma_gnt, bus_address, bus_r_w, bus_owner
  );
endinterface

// File: rtl/dma_bank_arbiter.sv
// Shares the 20-bit banked bus between 6502 and one DMA master; decisions at phi2 falling edges.
// Grant >= 2 bus cycles after request (more while CPU writes); CPU stalled via RDY, DMA via withheld grant.
module dma_bank_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CPU_SLOTS = 1
) (
  input logic               clock,
  input logic               reset,
  dma_bank_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_HALT = 2'd1,
    ST_DMA  = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] COOL_INIT  = 8'(CPU_SLOTS);

  state_t     state;
  state_t     state_nxt;
  logic       phi2_q;
  logic       rw_last;
  logic       boundary;
  logic       release_dma;
  logic       owner;
  logic [7:0] burst_cnt;
  logic [7:0] cool_cnt;

  assign boundary    = phi2_q & ~bus.phi2;
  assign release_dma = ~bus.dma_req | (burst_cnt == BURST_LAST);

  // rw_last keeps the R/W of the bus cycle that just ended
  always_ff @(posedge clock) begin
    if (reset) begin
      phi2_q  <= 1'b0;
      rw_last <= 1'b1;
    end else begin
      phi2_q <= bus.phi2;
      if (bus.phi2) begin
        rw_last <= bus.cpu_r_w;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_CPU;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (boundary) begin
      case (state)
        ST_CPU: begin
          if (cool_cnt == 8'd0 && bus.dma_req) begin
            state_nxt = ST_HALT;
          end
        end
        ST_HALT: begin
          // a write cycle ignores RDY, so wait for a read before handing over
          if (!bus.dma_req) begin
            state_nxt = ST_CPU;
          end else if (rw_last) begin
            state_nxt = ST_DMA;
          end
        end
        ST_DMA: begin
          if (release_dma) begin
            state_nxt = ST_CPU;
          end
        end
        default: state_nxt = ST_CPU;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      burst_cnt <= 8'd0;
      cool_cnt  <= 8'd0;
    end else if (boundary) begin
      case (state)
        ST_CPU: begin
          if (cool_cnt != 8'd0) begin
            cool_cnt <= cool_cnt - 8'd1;
          end
        end
        ST_HALT: begin
          if (bus.dma_req && rw_last) begin
            burst_cnt <= 8'd0;
          end
        end
        ST_DMA: begin
          if (release_dma) begin
            cool_cnt <= COOL_INIT;
          end else begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        default: begin
          burst_cnt <= 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    owner           = (state == ST_DMA);
    bus.cpu_rdy     = (state == ST_CPU);
    bus.dma_gnt     = owner;
    bus.bus_owner   = owner;
    bus.bus_address = owner ? bus.dma_address : {bus.cpu_bank, bus.cpu_address};
    bus.bus_r_w     = owner ? bus.dma_r_w : bus.cpu_r_w;
  end

endmodule

// File: tb/tb_dma_bank_arbiter.sv
// Drives two arbiters (burst 4 / 2 CPU slots, and burst 1 / no slots) with shared bus cycles
// and compares every output against a bus-cycle-level ownership model.
module tb_dma_bank_arbiter;

  localparam int M_CPU  = 0;
  localparam int M_HALT = 1;
  localparam int M_DMA  = 2;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  dma_bank_arbiter_if if0 ();
  dma_bank_arbiter_if if1 ();

  dma_bank_arbiter #(.MAX_BURST(4), .CPU_SLOTS(2)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (if0)
  );

  dma_bank_arbiter #(.MAX_BURST(1), .CPU_SLOTS(0)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (if1)
  );

  int checks = 0;
  int errors = 0;

  int maxb[2]   = '{4, 1};
  int cslots[2] = '{2, 0};
  int mode[2];
  int granted[2];
  int slots_left[2];

  logic        phi2;
  logic        req;
  logic        rw;
  logic        drw;
  logic [3:0]  bank;
  logic [15:0] addr;
  logic [19:0] daddr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    if0.phi2 = phi2;  if0.cpu_r_w = rw;  if0.cpu_address = addr;  if0.cpu_bank = bank;
    if0.dma_req = req; if0.dma_r_w = drw; if0.dma_address = daddr;
    if1.phi2 = phi2;  if1.cpu_r_w = rw;  if1.cpu_address = addr;  if1.cpu_bank = bank;
    if1.dma_req = req; if1.dma_r_w = drw; if1.dma_address = daddr;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i]       = M_CPU;
      granted[i]    = 0;
      slots_left[i] = 0;
    end
  endtask

  // One bus-cycle boundary: req and the R/W of the cycle just ended decide ownership.
  task automatic model_step(input int i, input bit r, input bit read_cycle);
    case (mode[i])
      M_CPU: begin
        if (slots_left[i] > 0) slots_left[i]--;
        else if (r) mode[i] = M_HALT;
      end
      M_HALT: begin
        if (!r) mode[i] = M_CPU;
        else if (read_cycle) begin
          mode[i]    = M_DMA;
          granted[i] = 1;
        end
      end
      default: begin
        if (!r || granted[i] >= maxb[i]) begin
          mode[i]       = M_CPU;
          slots_left[i] = cslots[i];
        end else begin
          granted[i]++;
        end
      end
    endcase
  endtask

  task automatic compare_all(input string where);
    logic        o_rdy, o_gnt, o_own, o_rw;
    logic [19:0] o_addr;
    bit          dma_owns;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        o_rdy = if0.cpu_rdy; o_gnt = if0.dma_gnt; o_own = if0.bus_owner;
        o_rw = if0.bus_r_w; o_addr = if0.bus_address;
      end else begin
        o_rdy = if1.cpu_rdy; o_gnt = if1.dma_gnt; o_own = if1.bus_owner;
        o_rw = if1.bus_r_w; o_addr = if1.bus_address;
      end
      dma_owns = (mode[i] == M_DMA);
      check($sformatf("%s_rdy%0d", where, i), 32'(o_rdy), 32'(mode[i] == M_CPU));
      check($sformatf("%s_gnt%0d", where, i), 32'(o_gnt), 32'(dma_owns));
      check($sformatf("%s_own%0d", where, i), 32'(o_own), 32'(dma_owns));
      check($sformatf("%s_addr%0d", where, i), 32'(o_addr), 32'(dma_owns ? daddr : {bank, addr}));
      check($sformatf("%s_rw%0d", where, i), 32'(o_rw), 32'(dma_owns ? drw : rw));
    end
  endtask

  // Entered and left #1 after a clock edge with phi2 low.
  task automatic bus_cycle(input bit req_v, input bit rw_v, input bit rst_v);
    int h;
    int l;
    h   = $urandom_range(1, 3);
    l   = rst_v ? $urandom_range(2, 3) : $urandom_range(1, 3);
    req = req_v;
    rw  = rw_v;
    drw = 1'($urandom_range(0, 1));
    drive();
    #1;
    compare_all("hold");
    phi2 = 1'b1;
    drive();
    repeat (h) @(posedge clock);
    #1;
    phi2 = 1'b0;
    drive();
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) model_step(i, req_v, rw_v);
    compare_all("bnd");
    for (int k = 1; k < l; k++) begin
      if (rst_v && k == 1) begin
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        compare_all("rst");
      end else begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) bus_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    phi2  = 1'b0;
    req   = 1'b0;
    rw    = 1'b1;
    drw   = 1'b1;
    bank  = 4'hF;
    addr  = 16'h1234;
    daddr = 20'h2ABCD;
    drive();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    compare_all("reset");

    idle(20);
    check("idle_addr", 32'(if0.bus_address), 32'h000F1234);

    // basic grant: request on a read, hold 4 cycles, then withdraw
    for (int k = 0; k < 5; k++) bus_cycle(1'b1, 1'b1, 1'b0);
    bus_cycle(1'b0, 1'b1, 1'b0);
    idle(4);

    // three CPU writes defer the hand-over
    bus_cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) bus_cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) bus_cycle(1'b1, 1'b1, 1'b0);
    bus_cycle(1'b0, 1'b1, 1'b0);
    idle(4);

    // burst cap and guaranteed CPU slots with the request held high
    for (int k = 0; k < 24; k++) bus_cycle(1'b1, 1'b1, 1'b0);
    idle(4);

    // withdraw while halting
    bus_cycle(1'b1, 1'b1, 1'b0);
    bus_cycle(1'b0, 1'b1, 1'b0);
    idle(4);

    // reset during the second cycle of a grant, request kept high
    bus_cycle(1'b1, 1'b1, 1'b0);
    bus_cycle(1'b1, 1'b1, 1'b0);
    bus_cycle(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) bus_cycle(1'b1, 1'b1, 1'b0);
    idle(4);

    for (int k = 0; k < 500; k++) begin
      bit nreq;
      bank  = 4'($urandom_range(0, 15));
      addr  = 16'($urandom_range(0, 65535));
      daddr = 20'($urandom_range(0, 20'hFFFFF));
      nreq  = ($urandom_range(0, 5) == 0) ? ~req : req;
      bus_cycle(nreq, ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
